// File: rtl/force_accumulator.sv
// -----------------------------------------------------------------------------
// force_accumulator
//
// Computes the net signed gravitational force on one object by sweeping its
// position against every entry of a position memory.  For each body it
// forms |dx| and |dy|, hands them to an external inverse-cube unit, scales
// the result, and accumulates signed X and Y force terms with saturation.
//
// Pipeline (one body per cycle, no stalls):
//   E0      : start accepted, rd_idx=0 issued
//   read    : 1-cycle RAM returns rd_x/rd_y
//   stage 1 : |dx|, |dy|, signs, skip flag registered (inv_dx/inv_dy)
//   stage 2 : distance * inv_cube, shift, clamp, apply sign
//   stage 3 : saturating accumulate; last body also publishes outputs + done
//   The last body retires N_BODIES+3 edges after E0.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               begin a sweep (accepted in IDLE only, not in done cycle)
//   self_idx/x/y        object index and position, latched on accepted start
//   rd_en, rd_idx       position memory read strobe/address
//   rd_x, rd_y          read data, valid the cycle after rd_en
//   inv_dx, inv_dy      |dx|, |dy| to the inverse-cube unit
//   inv_cube            1/(dx^2+dy^2)^1.5, unsigned 0.INV_W fraction, same cycle
//   busy                high from start accept until done
//   done                one-cycle pulse; x_force/y_force valid from this cycle
//   x_force, y_force    net force, two's complement with FRAC_W fraction bits
// -----------------------------------------------------------------------------
module force_accumulator #(
  parameter  int N_BODIES = 8,
  parameter  int X_W      = 7,
  parameter  int Y_W      = 6,
  parameter  int INV_W    = 20,
  parameter  int G_SHIFT  = 3,
  parameter  int FRAC_W   = 8,
  parameter  int FORCE_W  = 14,
  localparam int IDX_W    = $clog2(N_BODIES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [IDX_W-1:0]   self_idx,
  input  logic [X_W-1:0]     self_x,
  input  logic [Y_W-1:0]     self_y,
  output logic               rd_en,
  output logic [IDX_W-1:0]   rd_idx,
  input  logic [X_W-1:0]     rd_x,
  input  logic [Y_W-1:0]     rd_y,
  output logic [X_W-1:0]     inv_dx,
  output logic [Y_W-1:0]     inv_dy,
  input  logic [INV_W-1:0]   inv_cube,
  output logic               busy,
  output logic               done,
  output logic [FORCE_W-1:0] x_force,
  output logic [FORCE_W-1:0] y_force
);

  // Product of distance and inverse cube is 0.INV_W fixed point; multiplying
  // by G = 2^G_SHIFT and keeping FRAC_W fraction bits is a single right shift.
  localparam int SHIFT = INV_W - G_SHIFT - FRAC_W;
  localparam int PX_W  = X_W + INV_W;
  localparam int PY_W  = Y_W + INV_W;
  localparam int F_MAX = (1 << (FORCE_W - 1)) - 1;

  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(N_BODIES - 1);
  localparam logic [FORCE_W-1:0]        MAG_MAX  = FORCE_W'(F_MAX);
  localparam logic [PX_W-1:0]           PX_MAX   = PX_W'(F_MAX);
  localparam logic [PY_W-1:0]           PY_MAX   = PY_W'(F_MAX);
  localparam logic signed [FORCE_W:0]   SUM_MAX  = (FORCE_W + 1)'(F_MAX);
  localparam logic signed [FORCE_W:0]   SUM_MIN  = -SUM_MAX;
  localparam logic signed [FORCE_W-1:0] F_POS    = FORCE_W'(F_MAX);
  localparam logic signed [FORCE_W-1:0] F_NEG    = -F_POS;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t               state;
  logic [IDX_W-1:0]     self_idx_q;
  logic [X_W-1:0]       self_x_q;
  logic [Y_W-1:0]       self_y_q;

  // Read-data alignment (valid in the cycle RAM data is on rd_x/rd_y)
  logic                 d_valid, d_last;
  logic [IDX_W-1:0]     d_idx;
  // Stage 1 (inv_dx/inv_dy are the stage-1 distance registers)
  logic                 s1_valid, s1_last, s1_skip, s1_sx, s1_sy;
  // Stage 2
  logic                 s2_valid, s2_last;
  logic signed [FORCE_W-1:0] s2_fx, s2_fy;
  // Stage 3
  logic signed [FORCE_W-1:0] acc_x, acc_y;

  // Combinational stage-2 / stage-3 values
  logic [PX_W-1:0]           prod_x, shx;
  logic [PY_W-1:0]           prod_y, shy;
  logic [FORCE_W-1:0]        mag_x, mag_y;
  logic signed [FORCE_W-1:0] term_x, term_y, sum_x, sum_y;
  logic                      accept;

  // Two's complement add that clamps symmetrically to +/-F_MAX instead of wrapping.
  function automatic logic signed [FORCE_W-1:0] sat_add(
    input logic signed [FORCE_W-1:0] a,
    input logic signed [FORCE_W-1:0] b
  );
    logic signed [FORCE_W:0] s;
    s = (FORCE_W + 1)'(a) + (FORCE_W + 1)'(b);
    if (s > SUM_MAX)      sat_add = F_POS;
    else if (s < SUM_MIN) sat_add = F_NEG;
    else                  sat_add = s[FORCE_W-1:0];
  endfunction

  // The done cycle is already IDLE, but a start there must not launch a sweep.
  assign accept = (state == S_IDLE) && start && !done;

  // NOTE: every signal below is assigned on every path through the block, so
  // no storage is implied and the logic stays purely combinational.
  always_comb begin
    prod_x = PX_W'(inv_dx) * PX_W'(inv_cube);
    prod_y = PY_W'(inv_dy) * PY_W'(inv_cube);
    shx    = prod_x >> SHIFT;
    shy    = prod_y >> SHIFT;
    mag_x  = (shx > PX_MAX) ? MAG_MAX : shx[FORCE_W-1:0];
    mag_y  = (shy > PY_MAX) ? MAG_MAX : shy[FORCE_W-1:0];
    // Force points toward the other body: positive when it lies at a larger coordinate.
    term_x = s1_skip ? '0 : (s1_sx ? $signed(mag_x) : -$signed(mag_x));
    term_y = s1_skip ? '0 : (s1_sy ? $signed(mag_y) : -$signed(mag_y));
    sum_x  = sat_add(acc_x, s2_fx);
    sum_y  = sat_add(acc_y, s2_fy);
  end

  // Control FSM: read sequencing, busy/done and the published results.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_idx     <= '0;
      self_idx_q <= '0;
      self_x_q   <= '0;
      self_y_q   <= '0;
      x_force    <= '0;
      y_force    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_FETCH;
            busy       <= 1'b1;
            rd_en      <= 1'b1;
            rd_idx     <= '0;
            self_idx_q <= self_idx;
            self_x_q   <= self_x;
            self_y_q   <= self_y;
          end
        end
        S_FETCH: begin
          if (rd_idx == LAST_IDX) begin
            rd_en  <= 1'b0;
            rd_idx <= '0;
            state  <= S_DRAIN;
          end else begin
            rd_idx <= rd_idx + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          if (s2_valid && s2_last) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            x_force <= sum_x;
            y_force <= sum_y;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath pipeline and accumulators.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_valid  <= 1'b0;
      d_last   <= 1'b0;
      d_idx    <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_skip  <= 1'b0;
      s1_sx    <= 1'b0;
      s1_sy    <= 1'b0;
      inv_dx   <= '0;
      inv_dy   <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_fx    <= '0;
      s2_fy    <= '0;
      acc_x    <= '0;
      acc_y    <= '0;
    end else begin
      // RAM data appears one cycle after the read, so the address and last
      // flag are delayed alongside it.
      d_valid <= rd_en;
      d_idx   <= rd_idx;
      d_last  <= rd_en && (rd_idx == LAST_IDX);

      s1_valid <= d_valid;
      s1_last  <= d_valid && d_last;
      if (d_valid) begin
        inv_dx  <= (rd_x > self_x_q) ? rd_x - self_x_q : self_x_q - rd_x;
        inv_dy  <= (rd_y > self_y_q) ? rd_y - self_y_q : self_y_q - rd_y;
        s1_sx   <= rd_x > self_x_q;
        s1_sy   <= rd_y > self_y_q;
        // The object itself, or any body at the same spot, exerts no force.
        s1_skip <= (d_idx == self_idx_q) || ((rd_x == self_x_q) && (rd_y == self_y_q));
      end

      s2_valid <= s1_valid;
      s2_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        s2_fx <= term_x;
        s2_fy <= term_y;
      end

      if (accept) begin
        acc_x <= '0;
        acc_y <= '0;
      end else if (s2_valid) begin
        acc_x <= sum_x;
        acc_y <= sum_y;
      end
    end
  end

endmodule

// File: tb/tb_force_accumulator.sv
// -----------------------------------------------------------------------------
// tb_force_accumulator
//
// Drives force_accumulator (N_BODIES=8) with a 1-cycle position RAM model and
// a deterministic inverse-cube stub.  Expected forces come from a per-body
// arithmetic model of the force rules; latency, busy/done behaviour, read
// coverage, start filtering and asynchronous abort are also checked.
// -----------------------------------------------------------------------------
module tb_force_accumulator;

  localparam int N     = 8;
  localparam int IDXW  = 3;
  localparam int XW    = 7;
  localparam int YW    = 6;
  localparam int IW    = 20;
  localparam int FW    = 14;
  localparam int SHIFT = IW - 3 - 8;
  localparam int FMAX  = (1 << (FW - 1)) - 1;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic [IDXW-1:0]      self_idx = '0;
  logic [XW-1:0]        self_x = '0;
  logic [YW-1:0]        self_y = '0;
  logic                 rd_en;
  logic [IDXW-1:0]      rd_idx;
  logic [XW-1:0]        rd_x = '0;
  logic [YW-1:0]        rd_y = '0;
  logic [XW-1:0]        inv_dx;
  logic [YW-1:0]        inv_dy;
  logic [IW-1:0]        inv_cube;
  logic                 busy, done;
  logic signed [FW-1:0] x_force, y_force;

  // Inverse-cube stub configuration
  bit                   inv_const_en = 1'b1;
  int unsigned          inv_seed = 0;
  int                   inv_sh = 0;

  logic [XW-1:0]        mem_x [N];
  logic [YW-1:0]        mem_y [N];
  int                   rd_hits [N];
  int                   done_cnt = 0;

  int checks = 0;
  int errors = 0;

  force_accumulator #(
    .N_BODIES(N), .X_W(XW), .Y_W(YW), .INV_W(IW),
    .G_SHIFT(3), .FRAC_W(8), .FORCE_W(FW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .self_idx(self_idx), .self_x(self_x), .self_y(self_y),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
    .inv_dx(inv_dx), .inv_dy(inv_dy), .inv_cube(inv_cube),
    .busy(busy), .done(done), .x_force(x_force), .y_force(y_force)
  );

  always #5 clk = ~clk;

  // Arbitrary but repeatable inverse-cube value for a distance pair.
  function automatic logic [IW-1:0] inv_fn(int adx, int ady, int unsigned seed, int sh);
    int unsigned h;
    h = (int'(adx) * 1237 + int'(ady) * 4091 + seed) * 32'd40503;
    return IW'(h >> 9) >> sh;
  endfunction

  assign inv_cube = inv_const_en ? 20'hFFFFF
                                 : inv_fn(int'(inv_dx), int'(inv_dy), inv_seed, inv_sh);

  // 1-cycle synchronous position RAM
  always @(posedge clk) begin
    if (rd_en) begin
      rd_x <= mem_x[rd_idx];
      rd_y <= mem_y[rd_idx];
    end
  end

  always @(negedge clk) begin
    if (rd_en) rd_hits[rd_idx] = rd_hits[rd_idx] + 1;
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clamp(longint v);
    if (v > FMAX) return FMAX;
    if (v < -FMAX) return -FMAX;
    return v;
  endfunction

  // Reference: sum of per-body force terms, in index order, with saturation.
  function automatic void model(input int sidx, input int sx, input int sy,
                                output longint fx, output longint fy);
    fx = 0;
    fy = 0;
    for (int i = 0; i < N; i++) begin
      int dx, dy, adx, ady;
      longint inv, tx, ty;
      dx = int'(mem_x[i]) - sx;
      dy = int'(mem_y[i]) - sy;
      if (i == sidx || (dx == 0 && dy == 0)) continue;
      adx = (dx < 0) ? -dx : dx;
      ady = (dy < 0) ? -dy : dy;
      inv = inv_const_en ? longint'(20'hFFFFF) : longint'(inv_fn(adx, ady, inv_seed, inv_sh));
      tx = (longint'(adx) * inv) >> SHIFT;
      ty = (longint'(ady) * inv) >> SHIFT;
      if (tx > FMAX) tx = FMAX;
      if (ty > FMAX) ty = FMAX;
      if (dx <= 0) tx = -tx;
      if (dy <= 0) ty = -ty;
      fx = clamp(fx + tx);
      fy = clamp(fy + ty);
    end
  endfunction

  task automatic set_all(input int x, input int y);
    for (int i = 0; i < N; i++) begin
      mem_x[i] = XW'(x);
      mem_y[i] = YW'(y);
    end
  endtask

  task automatic run_sweep(input string tag, input int sidx, input int sx, input int sy,
                           input bit hammer);
    longint ex, ey;
    logic signed [FW-1:0] prev_x, prev_y;
    int cyc, d0;
    bit got, held, reads_ok;
    model(sidx, sx, sy, ex, ey);
    for (int i = 0; i < N; i++) rd_hits[i] = 0;
    d0 = done_cnt;
    prev_x = x_force;
    prev_y = y_force;
    held = 1'b1;
    got = 1'b0;
    @(negedge clk);
    start = 1'b1;
    self_idx = IDXW'(sidx);
    self_x = XW'(sx);
    self_y = YW'(sy);
    @(posedge clk);  // E0
    #1;
    if (!hammer) start = 1'b0;
    // Inputs are only sampled at E0; scramble them to prove it.
    self_idx = IDXW'($urandom);
    self_x = XW'($urandom);
    self_y = YW'($urandom);
    check({tag, "_busy_e0"}, busy, 1);
    cyc = 0;
    while (cyc < 40 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) got = 1'b1;
      else if (x_force !== prev_x || y_force !== prev_y) held = 1'b0;
    end
    check({tag, "_latency"}, got ? cyc : -1, N + 3);
    check({tag, "_held"}, held, 1);
    check({tag, "_x"}, x_force, ex);
    check({tag, "_y"}, y_force, ey);
    check({tag, "_busy_done"}, busy, 0);
    @(posedge clk);  // start may still be high here: done cycle, must be ignored
    #1;
    start = 1'b0;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_done_cnt"}, done_cnt - d0, 1);
    reads_ok = 1'b1;
    for (int i = 0; i < N; i++) if (rd_hits[i] != 1) reads_ok = 1'b0;
    check({tag, "_reads"}, reads_ok, 1);
  endtask

  task automatic abort_sweep(input int sidx, input int sx, input int sy);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    self_idx = IDXW'(sidx);
    self_x = XW'(sx);
    self_y = YW'(sy);
    @(posedge clk);  // E0
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_x", x_force, 0);
    check("abort_y", y_force, 0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    set_all(10, 10);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_idx", rd_idx, 0);
    check("rst_inv_dx", inv_dx, 0);
    check("rst_inv_dy", inv_dy, 0);
    check("rst_x", x_force, 0);
    check("rst_y", y_force, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single neighbour one step right: 1 * 0xFFFFF >> 9 = 2047
    inv_const_en = 1'b1;
    set_all(10, 10);
    mem_x[1] = 11;
    run_sweep("single", 0, 10, 10, 1'b0);
    check("single_gold", x_force, 2047);

    // Symmetric neighbour on the other side cancels
    mem_x[2] = 9;
    run_sweep("cancel", 0, 10, 10, 1'b0);
    check("cancel_gold", x_force, 0);

    // Five +1 neighbours saturate at +8191
    set_all(10, 10);
    for (int i = 1; i <= 5; i++) mem_x[i] = 11;
    run_sweep("sat_pos", 0, 10, 10, 1'b0);
    check("sat_pos_gold", x_force, 8191);

    // Saturated value recovers when an opposite term follows
    mem_x[6] = 9;
    run_sweep("sat_back", 0, 10, 10, 1'b0);
    check("sat_back_gold", x_force, 6144);

    // Y axis only, pointing downward
    set_all(10, 10);
    mem_y[4] = 9;
    run_sweep("y_only", 0, 10, 10, 1'b0);
    check("y_only_gold", y_force, -2047);

    // Mirrored: five -1 neighbours saturate at -8191
    set_all(10, 10);
    for (int i = 1; i <= 5; i++) mem_x[i] = 9;
    run_sweep("sat_neg", 0, 10, 10, 1'b0);
    check("sat_neg_gold", x_force, -8191);

    // Abort mid-sweep, then a clean sweep
    abort_sweep(0, 10, 10);
    set_all(10, 10);
    mem_x[1] = 11;
    run_sweep("post_abort", 0, 10, 10, 1'b0);
    check("post_abort_gold", x_force, 2047);

    // All bodies coincident with self, start hammered every cycle
    set_all(10, 10);
    run_sweep("coincident", 3, 10, 10, 1'b1);
    check("coincident_gold", x_force, 0);

    // Randomised sweeps
    for (int t = 0; t < 30; t++) begin
      bit narrow;
      int sx, sy;
      narrow = ($urandom_range(0, 1) == 1);
      inv_const_en = ($urandom_range(0, 3) == 0);
      inv_seed = $urandom;
      inv_sh = $urandom_range(0, 10);
      for (int i = 0; i < N; i++) begin
        mem_x[i] = narrow ? XW'(8 + $urandom_range(0, 4)) : XW'($urandom);
        mem_y[i] = narrow ? YW'(8 + $urandom_range(0, 4)) : YW'($urandom);
      end
      sx = narrow ? 8 + $urandom_range(0, 4) : $urandom_range(0, 127);
      sy = narrow ? 8 + $urandom_range(0, 4) : $urandom_range(0, 63);
      run_sweep($sformatf("rand%0d", t), $urandom_range(0, N - 1), sx, sy,
                $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
